mlp_init_loader: RTL

Upstream feeder for `mlp_fsm`. It accepts one load request, then streams a fixed-length sequence of data words over a valid/ready input: first the full weight image, then the input-activation image. It writes each word into the weight SRAM (W) or activation SRAM (X) through registered write ports. Once every word is written it raises `init_valid_o`, which drives the FSM's `init_valid_i`.

---
 rtl/mlp_init_loader.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mlp_init_loader.sv
// ============================================================================
// mlp_init_loader
// ----------------------------------------------------------------------------
// Upstream feeder for mlp_fsm. The block accepts one load request and then
// takes a fixed-length word stream over a valid/ready handshake. The first
// W_DEPTH words go to the weight SRAM (W) and the next X_DEPTH words go to
// bank 0 of the activation SRAM (X). Both SRAMs are written through
// registered write ports. When the last word has been written, init_valid_o
// rises and stays high until init_ready_i accepts it.
//
// Optional feature (macro MLP_LOADER_CHECKSUM_EN):
//   When the macro is defined, the block adds checksum_o[15:0]. This is the
//   modulo-2^16 sum of every accepted stream word. It is cleared when a load
//   starts and is valid while init_valid_o is high. When the macro is not
//   defined, the port and its adder do not exist.
//
// Parameters:
//   DATA_W   width of a stream word and of each SRAM write-data port
//   W_DEPTH  number of weight words loaded      (<= 2048)
//   X_DEPTH  number of activation words loaded  (<= 256)
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous active-low reset
//   load_valid_i  load request; accepted only while load_ready_o is high
//   load_ready_o  high only in IDLE (low while in reset)
//   s_valid_i     stream word valid
//   s_ready_o     loader accepts a word (LOAD_W / LOAD_X)
//   s_data_i      stream word
//   w_wen_o       weight SRAM write strobe (one pulse per beat)
//   w_addr_o      weight SRAM address
//   w_wdata_o     weight SRAM write data
//   x_wen_o       activation SRAM write strobe (one pulse per beat)
//   x_sel_o       activation bank select, tied to bank 0
//   x_addr_o      activation SRAM address
//   x_wdata_o     activation SRAM write data
//   init_valid_o  load complete, held until accepted
//   init_ready_i  downstream FSM accepts completion
//   checksum_o    (MLP_LOADER_CHECKSUM_EN only) sum of accepted words
// ============================================================================
module mlp_init_loader #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned W_DEPTH = 2048,
   parameter int unsigned X_DEPTH = 256
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_valid_i,
   output logic              load_ready_o,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   input  logic [DATA_W-1:0] s_data_i,
   output logic              w_wen_o,
   output logic [10:0]       w_addr_o,
   output logic [DATA_W-1:0] w_wdata_o,
   output logic              x_wen_o,
   output logic              x_sel_o,
   output logic [7:0]        x_addr_o,
   output logic [DATA_W-1:0] x_wdata_o,
   output logic              init_valid_o,
   input  logic              init_ready_i
`ifdef MLP_LOADER_CHECKSUM_EN
   ,
   output logic [15:0]       checksum_o
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      LOAD_X = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Terminal counter values for the two phases.
   localparam logic [10:0] W_LAST = 11'(W_DEPTH - 1);
   localparam logic [10:0] X_LAST = 11'(X_DEPTH - 1);

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   state_e              state_q,      state_d;
   logic [10:0]         cnt_q,        cnt_d;
   logic                load_ready_q, load_ready_d;
   logic                s_ready_q,    s_ready_d;
   logic                w_wen_q,      w_wen_d;
   logic [10:0]         w_addr_q,     w_addr_d;
   logic [DATA_W-1:0]   w_wdata_q,    w_wdata_d;
   logic                x_wen_q,      x_wen_d;
   logic [7:0]          x_addr_q,     x_addr_d;
   logic [DATA_W-1:0]   x_wdata_q,    x_wdata_d;
   logic                init_valid_q, init_valid_d;
`ifdef MLP_LOADER_CHECKSUM_EN
   logic [15:0]         csum_q,       csum_d;
`endif

   logic beat_s;

   // A beat is a handshake on the stream. s_ready_q is registered, so it is
   // the same value that the upstream source sees.
   assign beat_s = s_valid_i & s_ready_q;

   // Next-state and next-output logic for the load sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      load_ready_d = load_ready_q;
      s_ready_d    = s_ready_q;
      // The strobes are single-cycle pulses. Address and data hold their
      // last captured values.
      w_wen_d      = 1'b0;
      w_addr_d     = w_addr_q;
      w_wdata_d    = w_wdata_q;
      x_wen_d      = 1'b0;
      x_addr_d     = x_addr_q;
      x_wdata_d    = x_wdata_q;
      init_valid_d = init_valid_q;
`ifdef MLP_LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif

      case (state_q)
         IDLE: begin
            // load_ready comes up on the first edge after reset release, and
            // then stays high for as long as the sequencer waits in IDLE.
            if (load_valid_i && load_ready_q) begin
               state_d      = LOAD_W;
               cnt_d        = 11'd0;
               load_ready_d = 1'b0;
               s_ready_d    = 1'b1;
`ifdef MLP_LOADER_CHECKSUM_EN
               csum_d       = 16'd0;
`endif
            end else begin
               load_ready_d = 1'b1;
            end
         end

         LOAD_W: begin
            if (beat_s) begin
               w_wen_d   = 1'b1;
               w_addr_d  = cnt_q;
               w_wdata_d = s_data_i;
`ifdef MLP_LOADER_CHECKSUM_EN
               csum_d    = csum_q + 16'(s_data_i);
`endif
               // s_ready stays high across the phase change, so the first X
               // word can be taken on the very next cycle.
               if (cnt_q == W_LAST) begin
                  cnt_d   = 11'd0;
                  state_d = LOAD_X;
               end else begin
                  cnt_d   = cnt_q + 11'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         LOAD_X: begin
            if (beat_s) begin
               x_wen_d   = 1'b1;
               x_addr_d  = cnt_q[7:0];
               x_wdata_d = s_data_i;
`ifdef MLP_LOADER_CHECKSUM_EN
               csum_d    = csum_q + 16'(s_data_i);
`endif
               // init_valid is registered on the same edge as the last X
               // strobe, so the two are high together.
               if (cnt_q == X_LAST) begin
                  cnt_d        = 11'd0;
                  state_d      = DONE;
                  s_ready_d    = 1'b0;
                  init_valid_d = 1'b1;
               end else begin
                  cnt_d        = cnt_q + 11'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end

         DONE: begin
            if (init_valid_q && init_ready_i) begin
               state_d      = IDLE;
               init_valid_d = 1'b0;
               load_ready_d = 1'b1;
            end else begin
               init_valid_d = 1'b1;
            end
         end

         default: begin
            // An illegal encoding goes back to a clean IDLE.
            state_d      = IDLE;
            cnt_d        = 11'd0;
            load_ready_d = 1'b0;
            s_ready_d    = 1'b0;
            init_valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers. The asynchronous reset removes the strobes
   // immediately and abandons any partial load.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= 11'd0;
         load_ready_q <= 1'b0;
         s_ready_q    <= 1'b0;
         w_wen_q      <= 1'b0;
         w_addr_q     <= 11'd0;
         w_wdata_q    <= '0;
         x_wen_q      <= 1'b0;
         x_addr_q     <= 8'd0;
         x_wdata_q    <= '0;
         init_valid_q <= 1'b0;
`ifdef MLP_LOADER_CHECKSUM_EN
         csum_q       <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         load_ready_q <= load_ready_d;
         s_ready_q    <= s_ready_d;
         w_wen_q      <= w_wen_d;
         w_addr_q     <= w_addr_d;
         w_wdata_q    <= w_wdata_d;
         x_wen_q      <= x_wen_d;
         x_addr_q     <= x_addr_d;
         x_wdata_q    <= x_wdata_d;
         init_valid_q <= init_valid_d;
`ifdef MLP_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign load_ready_o = load_ready_q;
   assign s_ready_o    = s_ready_q;
   assign w_wen_o      = w_wen_q;
   assign w_addr_o     = w_addr_q;
   assign w_wdata_o    = w_wdata_q;
   assign x_wen_o      = x_wen_q;
   assign x_sel_o      = 1'b0;
   assign x_addr_o     = x_addr_q;
   assign x_wdata_o    = x_wdata_q;
   assign init_valid_o = init_valid_q;
`ifdef MLP_LOADER_CHECKSUM_EN
   assign checksum_o   = csum_q;
`endif

endmodule
